// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the MAR/MDR memory front-end.
// State encoding, bus widths and counter width.
package mem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int ST_W   = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_RD     = 3'd1;
  localparam logic [ST_W-1:0] S_WSETUP = 3'd2;
  localparam logic [ST_W-1:0] S_WPULSE = 3'd3;
  localparam logic [ST_W-1:0] S_WHOLD  = 3'd4;
  localparam logic [ST_W-1:0] S_DONE   = 3'd5;

  // Down-counter preload: a phase of n cycles exits when count hits zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// mem_interface_if: strobe/address/data bundle between the front-end
// and the asynchronous 512x32 RAM.
interface mem_interface_if;
  import mem_pkg::*;

  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] Mdatain;

  modport master (
    output ram_read,
    output ram_write,
    output ram_address,
    output ram_wdata,
    input  Mdatain
  );

  modport slave (
    input  ram_read,
    input  ram_write,
    input  ram_address,
    input  ram_wdata,
    output Mdatain
  );

endinterface

// File: rtl/mem_fsm.sv
// mem_fsm: access sequencer for the RAM front-end.
// Owns state, phase counter, registered strobes, done and error pulses.
module mem_fsm
  import mem_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int WR_WIDTH = 1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic rd_req,
  input  logic wr_req,
  input  logic MARin,
  input  logic MDRin,
  output logic ram_read,
  output logic ram_write,
  output logic busy,
  output logic done,
  output logic protocol_err,
  output logic idle,
  output logic capture
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next state, counter reload/decrement and the MDR capture strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (rd_req && !wr_req) begin
          state_d = S_RD;
          cnt_d   = cnt_load(RD_WAIT);
        end else if (wr_req && !rd_req) begin
          state_d = S_WSETUP;
        end
      end
      (state_q == S_RD): begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == S_WSETUP): begin
        state_d = S_WPULSE;
        cnt_d   = cnt_load(WR_WIDTH);
      end
      (state_q == S_WPULSE): begin
        if (cnt_zero) begin
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == S_WHOLD): state_d = S_DONE;
      (state_q == S_DONE):  state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Strobes and done are decoded from the next state so they leave a flop.
  always_comb begin
    rd_d   = (state_d == S_RD);
    wr_d   = (state_d == S_WPULSE);
    done_d = (state_d == S_DONE);
  end

  // State, counter and registered outputs; reset drops strobes at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign idle      = (state_q == S_IDLE);
  assign busy      = !idle;
  assign ram_read  = rd_q;
  assign ram_write = wr_q;
  assign done      = done_q;

  // Any load/request while busy, or a read+write collision in idle.
  assign protocol_err = (busy && (MARin || MDRin || rd_req || wr_req))
                      || (idle && rd_req && wr_req);

endmodule

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR front-end for the 512x32 asynchronous RAM.
// Registers live here; access sequencing is delegated to mem_fsm.
module mem_interface
  import mem_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int WR_WIDTH = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_req,
  input  logic              wr_req,
  mem_interface_if.master   ram,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              protocol_err
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_d;
  logic              idle;
  logic              capture;
  logic              ram_read;
  logic              ram_write;

  mem_fsm #(
    .RD_WAIT  (RD_WAIT),
    .WR_WIDTH (WR_WIDTH)
  ) u_fsm (
    .clk          (clk),
    .clr_n        (clr_n),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .busy         (busy),
    .done         (done),
    .protocol_err (protocol_err),
    .idle         (idle),
    .capture      (capture)
  );

  // Bus loads only in idle; read capture only at the end of a read.
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (idle && MARin) begin
      mar_d = BusMuxOut[ADDR_W-1:0];
    end
    if (capture) begin
      mdr_d = ram.Mdatain;
    end else if (idle && MDRin) begin
      mdr_d = BusMuxOut;
    end
  end

  // MAR/MDR registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  assign ram.ram_read    = ram_read;
  assign ram.ram_write   = ram_write;
  assign ram.ram_address = mar_q;
  assign ram.ram_wdata   = mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed + random check of the MAR/MDR front-end
// against a transaction-level memory model.
module tb_mem_interface;

  localparam int RDW = 2;
  localparam int WRW = 1;

  logic        clk;
  logic        clr_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, rd_req, wr_req;
  logic [31:0] mdr_q;
  logic        busy, done, protocol_err;

  mem_interface_if ram_if ();

  mem_interface #(
    .RD_WAIT  (RDW),
    .WR_WIDTH (WRW)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .ram          (ram_if),
    .mdr_q        (mdr_q),
    .busy         (busy),
    .done         (done),
    .protocol_err (protocol_err)
  );

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  logic [8:0]  ref_mar;
  logic [31:0] ref_mdr;
  int total = 0;
  int bad   = 0;
  int overlap_seen = 0;
  int idle_strobe  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_if.Mdatain = mem[ram_if.ram_address];

  always @(negedge clk) begin
    if (ram_if.ram_write) mem[ram_if.ram_address] <= ram_if.ram_wdata;
    if (ram_if.ram_read && ram_if.ram_write) overlap_seen++;
    if (!busy && (ram_if.ram_read || ram_if.ram_write)) idle_strobe++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [8:0] a);
    @(negedge clk);
    BusMuxOut      = $urandom;
    BusMuxOut[8:0] = a;
    MARin          = 1'b1;
    @(negedge clk);
    MARin   = 1'b0;
    ref_mar = a;
    check("mar_load", 32'(ram_if.ram_address), 32'(a));
  endtask

  task automatic load_mdr(input logic [31:0] d);
    @(negedge clk);
    BusMuxOut = d;
    MDRin     = 1'b1;
    @(negedge clk);
    MDRin   = 1'b0;
    ref_mdr = d;
    check("mdr_load", ram_if.ram_wdata, d);
  endtask

  task automatic do_read(input bit poke);
    int rd_cnt;
    int done_at;
    logic [31:0] exp;
    exp = ref_mem[ref_mar];
    @(negedge clk);
    check("idle_before_rd", {30'd0, done, busy}, 32'd0);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
    rd_cnt  = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (c > 1) begin
        @(negedge clk);
        MARin = 1'b0;
      end
      if (c == 1) check("rd_busy", 32'(busy), 32'd1);
      if (poke && c == 1) begin
        BusMuxOut = $urandom;
        MARin     = 1'b1;
        #1;
        check("err_busy_marin", 32'(protocol_err), 32'd1);
      end
      if (ram_if.ram_read) rd_cnt++;
      if (done) done_at = c;
    end
    check("rd_strobe_len", rd_cnt, RDW);
    check("rd_done_at", done_at, RDW + 1);
    check("rd_data", mdr_q, exp);
    check("rd_mar_kept", 32'(ram_if.ram_address), 32'(ref_mar));
    ref_mdr = exp;
  endtask

  task automatic do_write();
    int first_w;
    int last_w;
    int done_at;
    bit stable;
    first_w = 0;
    last_w  = 0;
    done_at = 0;
    stable  = 1'b1;
    @(negedge clk);
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_if.ram_write) begin
        if (first_w == 0) first_w = c;
        last_w = c;
      end
      if (ram_if.ram_address !== ref_mar || ram_if.ram_wdata !== ref_mdr)
        stable = 1'b0;
      if (done) done_at = c;
    end
    check("wr_first", first_w, 2);
    check("wr_last", last_w, WRW + 1);
    check("wr_done_at", done_at, WRW + 3);
    check("wr_stable", 32'(stable), 32'd1);
    ref_mem[ref_mar] = ref_mdr;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[9'h055]     = 32'hDEAD_BEEF;
    ref_mem[9'h055] = 32'hDEAD_BEEF;
    ref_mar   = '0;
    ref_mdr   = '0;
    clr_n     = 1'b0;
    BusMuxOut = '0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    #1;
    check("rst_outs", {28'd0, ram_if.ram_read, ram_if.ram_write,
                       busy, done}, 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_addr", 32'(ram_if.ram_address), 32'd0);
    check("rst_mdr", mdr_q, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    // Address load, then read of preloaded word
    @(negedge clk);
    BusMuxOut = 32'h0000_0055;
    MARin     = 1'b1;
    @(negedge clk);
    MARin   = 1'b0;
    ref_mar = 9'h055;
    check("mar_55", 32'(ram_if.ram_address), 32'h055);
    do_read(1'b0);
    check("rd_beef", mdr_q, 32'hDEAD_BEEF);

    // Write to top address, then back-to-back readback
    load_mar(9'h1FF);
    load_mdr(32'h1234_5678);
    do_write();
    load_mdr(32'hA5A5_0000);
    do_read(1'b0);
    check("readback", mdr_q, 32'h1234_5678);
    do_write();
    do_read(1'b0);

    // Simultaneous read and write request
    @(negedge clk);
    rd_req = 1'b1;
    wr_req = 1'b1;
    #1;
    check("both_err", 32'(protocol_err), 32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    check("both_nostrobe", {29'd0, ram_if.ram_read, ram_if.ram_write,
                            busy}, 32'd0);
    #1;
    check("both_err_clr", 32'(protocol_err), 32'd0);

    // MARin during a read is ignored
    load_mar(9'h055);
    do_read(1'b1);

    // Random traffic
    for (int i = 0; i < 16; i++) begin
      load_mar(9'($urandom_range(0, 511)));
      if ($urandom_range(0, 1) == 1) begin
        load_mdr($urandom);
        do_write();
      end else begin
        do_read(1'b0);
      end
    end

    // Reset in the middle of a write pulse
    load_mar(9'h1AA);
    load_mdr(32'hCAFE_F00D);
    @(negedge clk);
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    for (int c = 0; c < 10 && !ram_if.ram_write; c++) @(negedge clk);
    check("rst_wr_seen", 32'(ram_if.ram_write), 32'd1);
    ref_mem[9'h1AA] = 32'hCAFE_F00D;
    #1;
    clr_n = 1'b0;
    #1;
    check("rst_wr_drop", {30'd0, ram_if.ram_write, ram_if.ram_read},
          32'd0);
    check("rst_mar0", 32'(ram_if.ram_address), 32'd0);
    check("rst_mdr0", mdr_q, 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    ref_mar = '0;
    ref_mdr = '0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    clr_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", seen, 0);
    do_read(1'b0);

    check("no_overlap", overlap_seen, 0);
    check("no_idle_strobe", idle_strobe, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
